// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings and FSM states.
package rv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed byte/half down to bit 0 and sign/zero-extends it.
module lsu_load_align
  import rv_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_word >> {i_off, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_funct3)
      F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_data = {24'd0, w_shifted[7:0]};
      F3_HU:   o_data = {16'd0, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a 1-cycle-latency data BRAM port.
module load_store_unit
  import rv_lsu_pkg::*;
#(
  parameter int MEM_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata
);

  lsu_state_t            r_state;
  logic [2:0]            r_f3;
  logic [1:0]            r_off;
  logic [MEM_ADDR_W-1:0] r_waddr;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [31:0]           r_resp_rdata;

  logic        w_accept;
  logic        w_err;
  logic        w_range;
  logic        w_illegal;
  logic        w_misalign;
  logic [31:0] w_ld_data;

  assign req_ready = (r_state == IDLE);
  // Gated by rst_n so the BRAM is never written while reset is held.
  assign w_accept  = req_valid & req_ready & rst_n;

  assign w_range    = |req_addr[31:MEM_ADDR_W+2];
  assign w_illegal  = req_we ? (req_funct3 > F3_W)
                             : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
  assign w_misalign = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) & req_addr[0])
                    | ((req_funct3 == F3_W) & (|req_addr[1:0]));
  assign w_err      = w_range | w_illegal | w_misalign;

  assign mem_we   = w_accept & req_we & ~w_err;
  assign mem_addr = (r_state == IDLE) ? req_addr[MEM_ADDR_W+1:2] : r_waddr;

  always_comb begin
    mem_wstrb = 4'b1111;
    mem_wdata = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        mem_wstrb = 4'b0001 << req_addr[1:0];
        mem_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        mem_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        mem_wstrb = 4'b1111;
        mem_wdata = req_wdata;
      end
    endcase
  end

  lsu_load_align u_align (
    .i_word   (mem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_f3         <= F3_W;
      r_off        <= 2'd0;
      r_waddr      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_f3    <= req_funct3;
            r_off   <= req_addr[1:0];
            r_waddr <= req_addr[MEM_ADDR_W+1:2];
            if (req_we || w_err) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_err;
              r_resp_rdata <= 32'd0;
            end else begin
              r_state <= LOAD_WAIT;
            end
          end
        end
        LOAD_WAIT: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= w_ld_data;
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule
